// File: rtl/tlc_pkg.sv
// Shared lamp codes and phase encoding for the traffic-light phase arbiter.
package tlc_pkg;

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;

   typedef enum logic [1:0] {
      PH_ALLRED = 2'b00,
      PH_GREEN  = 2'b01,
      PH_YELLOW = 2'b10,
      PH_WALK   = 2'b11
   } ph_t;

endpackage

// File: rtl/tlc_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 and strobes tick for one clk on the last count.
module tlc_tick_gen #(
   parameter int TICK_DIV = 4,
   parameter int CNT_W    = 28
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/tlc_phase_arbiter.sv
// Round-robin right-of-way scheduler over N_APP approaches; lamps registered, phases move on 1 s ticks.
// Optional pedestrian WALK phase is built when TLC_PED_EN is defined.
import tlc_pkg::*;

module tlc_phase_arbiter #(
   parameter int N_APP     = 4,
   parameter int TICK_DIV  = 4,
   parameter int GREEN_MIN = 5,
   parameter int GREEN_MAX = 10,
   parameter int YEL_T     = 3,
   parameter int ALLRED_T  = 1,
   parameter int CNT_W     = 28
`ifdef TLC_PED_EN
   ,
   parameter int WALK_T    = 5
`endif
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_APP-1:0]     req,
`ifdef TLC_PED_EN
   input  logic                 ped_req,
   output logic                 walk,
`endif
   output logic [3*N_APP-1:0]   light,
   output logic [2:0]           owner,
   output logic [1:0]           phase,
   output logic [N_APP-1:0]     pending,
   output logic                 tick
);

   localparam int TMR_W = 16;
   localparam logic [TMR_W-1:0] GMIN_L = TMR_W'(GREEN_MIN - 1);
   localparam logic [TMR_W-1:0] GMAX_L = TMR_W'(GREEN_MAX - 1);
   localparam logic [TMR_W-1:0] YEL_L  = TMR_W'(YEL_T - 1);
   localparam logic [TMR_W-1:0] AR_L   = TMR_W'(ALLRED_T - 1);
`ifdef TLC_PED_EN
   localparam logic [TMR_W-1:0] WALK_L = TMR_W'(WALK_T - 1);
   logic ped_pending;
`endif

   ph_t              ph_q;
   logic [TMR_W-1:0] timer;
   logic [N_APP-1:0] own_oh, pick_oh, set_mask;
   logic [7:0]       pend8;
   logic [2:0]       pick;
   logic             other, leave_green;

   tlc_tick_gen #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   function automatic logic [3*N_APP-1:0] lamps(input ph_t p, input logic [2:0] o);
      lamps = {N_APP{LAMP_RED}};
      for (int i = 0; i < N_APP; i++) begin
         if (3'(i) == o && p == PH_GREEN)  lamps[3*i +: 3] = LAMP_GRN;
         if (3'(i) == o && p == PH_YELLOW) lamps[3*i +: 3] = LAMP_YEL;
      end
   endfunction

   // Descending scan so the nearest pending approach after the owner wins.
   always_comb begin
      own_oh = {{(N_APP-1){1'b0}}, 1'b1} << owner;
      pend8  = 8'(pending);
      pick   = 3'd0;
      for (int k = N_APP; k >= 1; k--) begin
         if (pend8[3'((int'(owner) + k) % N_APP)])
            pick = 3'((int'(owner) + k) % N_APP);
      end
      pick_oh     = {{(N_APP-1){1'b0}}, 1'b1} << pick;
      other       = |(pending & ~own_oh);
      leave_green = other && ((timer == GMAX_L) ||
                              ((timer >= GMIN_L) && !(|(req & own_oh))));
      set_mask    = req & ~((ph_q == PH_GREEN) ? own_oh : '0);
   end

   assign phase = ph_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph_q    <= PH_ALLRED;
         owner   <= '0;
         timer   <= '0;
         pending <= '0;
         light   <= {N_APP{LAMP_RED}};
`ifdef TLC_PED_EN
         ped_pending <= 1'b0;
         walk        <= 1'b0;
`endif
      end else begin
         pending <= pending | set_mask;
`ifdef TLC_PED_EN
         if (ped_req) ped_pending <= 1'b1;
`endif
         case (ph_q)
            PH_ALLRED: if (tick) begin
               if (timer == AR_L) begin
                  timer <= '0;
`ifdef TLC_PED_EN
                  if (ped_pending) begin
                     ph_q        <= PH_WALK;
                     walk        <= 1'b1;
                     ped_pending <= 1'b0;
                  end else
`endif
                  begin
                     ph_q    <= PH_GREEN;
                     owner   <= pick;
                     light   <= lamps(PH_GREEN, pick);
                     pending <= (pending | set_mask) & ~pick_oh;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            PH_GREEN: if (tick) begin
               if (leave_green) begin
                  ph_q  <= PH_YELLOW;
                  timer <= '0;
                  light <= lamps(PH_YELLOW, owner);
               end else if (timer != GMAX_L) begin
                  timer <= timer + 1'b1;
               end
            end
            PH_YELLOW: if (tick) begin
               if (timer == YEL_L) begin
                  ph_q  <= PH_ALLRED;
                  timer <= '0;
                  light <= {N_APP{LAMP_RED}};
               end else begin
                  timer <= timer + 1'b1;
               end
            end
`ifdef TLC_PED_EN
            PH_WALK: if (tick) begin
               if (timer == WALK_L) begin
                  ph_q  <= PH_ALLRED;
                  timer <= '0;
                  walk  <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
`endif
            // Unreachable encoding: recover to a safe all-red home state.
            default: begin
               ph_q  <= PH_ALLRED;
               owner <= '0;
               timer <= '0;
               light <= {N_APP{LAMP_RED}};
            end
         endcase
      end
   end

endmodule

// File: doc/tlc_phase_arbiter.md
Name: tlc_phase_arbiter

Overview:
- Round-robin phase scheduler that shares the single intersection "right of way" among N_APP approach roads.
- Inputs are vehicle sensors; outputs are per-approach red/yellow/green lamp codes.
- Enforces minimum green, maximum green, yellow and all-red clearance times, counted in 1 s ticks from an internal prescaler.
- Generalises the two-road highway/farm controller to N approaches, with approach 0 as the home (main) road.

Parameters:
- N_APP, 4: number of approaches (2..8).
- TICK_DIV, 4: clk cycles per tick. Use 50_000_000 on the 50 MHz board and 4 for simulation.
- GREEN_MIN, 5: minimum green, in ticks (>=1).
- GREEN_MAX, 10: maximum green under contention, in ticks (>GREEN_MIN).
- YEL_T, 3: yellow duration, in ticks (>=1).
- ALLRED_T, 1: all-red clearance, in ticks (>=1).
- CNT_W, 28: prescaler width.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- req, input, N_APP: level vehicle sensors, one per approach.
- light, output, 3*N_APP: lamp code per approach, bits [3i+2:3i]. Codes: 100 red, 010 yellow, 001 green.
- owner, output, 3: index of the approach currently holding the right of way.
- phase, output, 2: 00 ALL_RED, 01 GREEN, 10 YELLOW.
- pending, output, N_APP: latched outstanding requests.
- tick, output, 1: one-cycle 1 s strobe.

Behaviour:
- Reset (async, mid-operation included):
  - phase=ALL_RED, owner=0, pending=0, tick timer=0, prescaler=0.
  - All lights 100. No approach is ever green out of reset.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 exactly in the cycle where count==TICK_DIV-1.
- Phase timer:
  - Increments on tick.
  - Cleared in the cycle of any phase change.
  - A phase with duration T exits on the tick where timer==T-1, so it lasts exactly T ticks.
  - Phase changes occur only on tick cycles. Outputs are registered and change in the cycle after that tick.
- pending[i]:
  - Set on any clk where req[i]=1, except when i==owner and phase==GREEN.
  - Cleared in the cycle approach i enters GREEN.
  - If set and clear coincide, clear wins.
- ALL_RED:
  - All lights 100.
  - On exit, pick the new owner: first set pending bit searching owner+1, owner+2, … with wrap modulo N_APP.
  - If no bit is set, owner=0 (home rest).
  - Next phase is GREEN.
- GREEN:
  - Owner light 001; all others 100.
  - "other" = any pending bit other than owner.
  - If other=0: rest in GREEN indefinitely. The timer saturates at GREEN_MAX-1; it does not wrap.
  - If other=1 and timer>=GREEN_MIN-1 and req[owner]=0: gap-out to YELLOW on tick.
  - If other=1 and timer==GREEN_MAX-1: max-out to YELLOW on tick, regardless of req[owner].
- YELLOW:
  - Owner light 010; others 100.
  - After YEL_T ticks go to ALL_RED; owner is unchanged until the ALL_RED exit.
- Invariants:
  - Never two approaches non-red at once.
  - Yellow always precedes all-red; all-red always precedes green.
  - A request arriving during yellow or all-red is considered at the next ALL_RED exit if latched before that tick cycle.
- Illegal phase encoding 11: next cycle is ALL_RED with owner=0.

Optional Feature:
- Macro: TLC_PED_EN.
- When defined, add ports ped_req (input, 1) and walk (output, 1), plus parameter WALK_T (default 5).
  - ped_req latches into ped_pending.
  - At an ALL_RED exit with ped_pending=1, ped_pending takes priority over vehicles and the phase goes to WALK (encoding 11, now legal).
  - WALK: all lights 100, walk=1 for WALK_T ticks, then ALL_RED again; ped_pending clears on WALK entry.
- When undefined: no ped ports, and encoding 11 stays illegal as above.

Decomposition:
- Shared package tlc_pkg holds:
  - lamp code constants LAMP_RED/LAMP_YEL/LAMP_GRN;
  - phase enum PH_ALLRED/PH_GREEN/PH_YELLOW/PH_WALK.
- One sub-module: tlc_tick_gen (prescaler; parameters TICK_DIV, CNT_W; outputs tick).

Test Plan (defaults, TICK_DIV=4):
- Reset release with req=0: all lights red for 1 tick (4 clk), then approach 0 green. Green holds >=50 ticks with no other request; timer does not wrap.
- Approach 0 green, req[2] pulsed 1 clk, req[0]=0: approach 0 stays green until 5 ticks, then yellow 3 ticks, red 1 tick, then approach 2 green. No two non-red lamps at any cycle.
- req[0] held 1, req[1]=1: max-out; approach 0 leaves green exactly at 10 ticks.
- owner=3 green with pending={1,2} set: next owner is 1 (wrap order 0,1,2), then 2.
- Assert rst_n low mid-YELLOW, asynchronously between clk edges: lights go all 100 immediately, and pending clears.
- TLC_PED_EN defined, ped_req pulsed during green of approach 1 with pending[2]=1: sequence is yellow, all-red, WALK 5 ticks (walk=1, all red), all-red, then approach 2 green.
